// File: rtl/remote_cmd_arbiter_pkg.sv
// Shared types and constants for the RemoteComm command arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, response value returned on timeout, default
// timeout length in cycles.
package remote_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_SENT,
    WAIT_RESP,
    DONE
  } arb_state_t;

  localparam logic [7:0] TIMEOUT_RESP    = 8'h00;
  localparam int         DEFAULT_TIMEOUT = 2**20;

endpackage

// File: rtl/remote_cmd_arbiter_if.sv
// Bundles requester-side and RemoteComm-side signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: req held until done; RemoteComm paced by cmd_sent/resp_rdy.
//
// Requester side : req, req_cmd (in to arbiter); gnt, done, resp_out,
//                  timeout_err (out of arbiter).
// RemoteComm side: cmd, send_cmd (out of arbiter); cmd_sent, resp_rdy,
//                  resp (in to arbiter).
// slave modport = the arbiter, master modport = sources + RemoteComm.
interface remote_cmd_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] req_cmd;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic [7:0]            resp_out;
  logic                  timeout_err;
  logic [15:0]           cmd;
  logic                  send_cmd;
  logic                  cmd_sent;
  logic                  resp_rdy;
  logic [7:0]            resp;

  modport slave (
    input  req, req_cmd, cmd_sent, resp_rdy, resp,
    output gnt, done, resp_out, timeout_err, cmd, send_cmd
  );

  modport master (
    output req, req_cmd, cmd_sent, resp_rdy, resp,
    input  gnt, done, resp_out, timeout_err, cmd, send_cmd
  );

endinterface

// File: rtl/remote_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin pick among pending requesters.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when to take the pick.
//
// Ports: i_req (pending mask), i_last_gnt (index granted last) ->
//        o_gnt (one-hot pick), o_gnt_idx (its index), o_any (i_req != 0).
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_gnt,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_any
);

  logic w_found;
  int   w_idx;

  // Scan starts one past the previous winner and wraps, so the previous
  // winner is considered last.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = |i_req;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(i_last_gnt) + k) % NUM_REQ;
      if (!w_found && i_req[w_idx]) begin
        w_found   = 1'b1;
        o_gnt_idx = IDX_W'(w_idx);
      end
    end
    if (w_found) begin
      o_gnt[o_gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/remote_cmd_arbiter.sv
// Shares one RemoteComm link among NUM_REQ requesters, round-robin.
// Latency: gnt 1 cycle after req seen in IDLE, send_cmd 1 later, done 1 after resp_rdy.
// Backpressure: one transaction at a time; others hold req until granted.
//
// Ports: clk, rst (async, active-high); bus (slave modport) carries
// req/req_cmd -> gnt/done/resp_out/timeout_err and
// cmd/send_cmd -> cmd_sent/resp_rdy/resp. All outputs are registered.
module remote_cmd_arbiter
  import remote_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  remote_cmd_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_t          r_state,        w_state_nxt;
  logic [IDX_W-1:0]    r_last_gnt,     w_last_gnt_nxt;
  logic [NUM_REQ-1:0]  r_gnt,          w_gnt_nxt;
  logic [NUM_REQ-1:0]  r_done,         w_done_nxt;
  logic [7:0]          r_resp_out,     w_resp_out_nxt;
  logic                r_timeout_err,  w_timeout_err_nxt;
  logic [15:0]         r_cmd,          w_cmd_nxt;
  logic                r_send_cmd,     w_send_cmd_nxt;
  logic [CNT_W-1:0]    r_cnt,          w_cnt_nxt;

  logic [NUM_REQ-1:0]  w_pick;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_any;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_expired;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req      (bus.req),
    .i_last_gnt (r_last_gnt),
    .o_gnt      (w_pick),
    .o_gnt_idx  (w_pick_idx),
    .o_any      (w_any)
  );

  // Saturating so a huge TIMEOUT can never wrap back to a small count.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_expired = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt       = r_state;
    w_last_gnt_nxt    = r_last_gnt;
    w_gnt_nxt         = r_gnt;
    w_done_nxt        = '0;
    w_resp_out_nxt    = r_resp_out;
    w_timeout_err_nxt = r_timeout_err;
    w_cmd_nxt         = r_cmd;
    w_send_cmd_nxt    = 1'b0;
    w_cnt_nxt         = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_gnt_nxt      = w_pick;
          w_last_gnt_nxt = w_pick_idx;
          w_cmd_nxt      = bus.req_cmd[int'(w_pick_idx)*16 +: 16];
          w_state_nxt    = SEND;
        end
      end
      SEND: begin
        w_send_cmd_nxt = 1'b1;
        w_cnt_nxt      = '0;
        w_state_nxt    = WAIT_SENT;
      end
      WAIT_SENT: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_expired) begin
          w_resp_out_nxt    = TIMEOUT_RESP;
          w_timeout_err_nxt = 1'b1;
          w_done_nxt        = r_gnt;
          w_state_nxt       = DONE;
        end else if (bus.cmd_sent && !r_send_cmd) begin
          // During the launch cycle cmd_sent still shows the previous
          // command's completion; RemoteComm clears it on send_cmd.
          w_state_nxt = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        w_cnt_nxt = w_cnt_inc;
        // A response in the expiry cycle still counts as success.
        if (bus.resp_rdy) begin
          w_resp_out_nxt    = bus.resp;
          w_timeout_err_nxt = 1'b0;
          w_done_nxt        = r_gnt;
          w_state_nxt       = DONE;
        end else if (w_expired) begin
          w_resp_out_nxt    = TIMEOUT_RESP;
          w_timeout_err_nxt = 1'b1;
          w_done_nxt        = r_gnt;
          w_state_nxt       = DONE;
        end
      end
      DONE: begin
        // Dead cycle: owner can drop req before the next arbitration.
        w_gnt_nxt         = '0;
        w_timeout_err_nxt = 1'b0;
        w_state_nxt       = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_last_gnt    <= IDX_W'(NUM_REQ - 1);
      r_gnt         <= '0;
      r_done        <= '0;
      r_resp_out    <= '0;
      r_timeout_err <= 1'b0;
      r_cmd         <= '0;
      r_send_cmd    <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_gnt    <= w_last_gnt_nxt;
      r_gnt         <= w_gnt_nxt;
      r_done        <= w_done_nxt;
      r_resp_out    <= w_resp_out_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_cmd         <= w_cmd_nxt;
      r_send_cmd    <= w_send_cmd_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.done        = r_done;
  assign bus.resp_out    = r_resp_out;
  assign bus.timeout_err = r_timeout_err;
  assign bus.cmd         = r_cmd;
  assign bus.send_cmd    = r_send_cmd;

endmodule

// File: tb/tb_remote_cmd_arbiter.sv
// Directed bench for remote_cmd_arbiter with a small RemoteComm model.
// Latency: n/a.
// Backpressure: model delays cmd_sent/resp_rdy by programmable cycle counts.
module tb_remote_cmd_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TO      = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  remote_cmd_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  remote_cmd_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  // RemoteComm model: cmd_sent sd cycles after send_cmd, resp_rdy rd cycles later.
  int         sd = 2, rd = 2, m_phase = 0, m_cnt = 0;
  logic       m_resp_en = 1'b1;
  logic [7:0] m_val = 8'h00, m_resp = 8'h00;
  logic       m_cmd_sent = 1'b0, m_resp_rdy = 1'b0;
  logic       f_resp_rdy = 1'b0;
  logic [7:0] f_resp = 8'h00;

  assign bus.cmd_sent = m_cmd_sent;
  assign bus.resp_rdy = m_resp_rdy | f_resp_rdy;
  assign bus.resp     = f_resp_rdy ? f_resp : m_resp;

  always begin
    @(posedge clk);
    #1;
    m_resp_rdy = 1'b0;
    if (rst) begin
      m_phase = 0;
      m_cmd_sent = 1'b0;
    end else if (bus.send_cmd) begin
      m_cmd_sent = 1'b0;
      m_cnt = 0;
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_cnt++;
      if (m_cnt == sd) begin
        m_cmd_sent = 1'b1;
        m_cnt = 0;
        m_phase = m_resp_en ? 2 : 0;
      end
    end else if (m_phase == 2) begin
      m_cnt++;
      if (m_cnt == rd) begin
        m_resp_rdy = 1'b1;
        m_resp = m_val;
        m_phase = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observes one transaction until done (bounded); no comparisons here.
  task automatic watch(output int n_send, output logic [15:0] s_cmd, output logic [3:0] s_gnt,
                       output int g_cyc, output int s_cyc, output logic [3:0] d_v,
                       output logic [7:0] d_resp, output logic d_to, output int d_cyc, output bit ok);
    n_send = 0; s_cmd = '0; s_gnt = '0; g_cyc = -1; s_cyc = -1;
    d_v = '0; d_resp = '0; d_to = 1'b0; d_cyc = -1; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (g_cyc < 0 && bus.gnt != 0) g_cyc = cyc;
      if (bus.send_cmd) begin
        n_send++; s_cmd = bus.cmd; s_gnt = bus.gnt; s_cyc = cyc;
      end
      if (bus.done != 0) begin
        d_v = bus.done; d_resp = bus.resp_out; d_to = bus.timeout_err; d_cyc = cyc; ok = 1'b1;
        break;
      end
    end
  endtask

  int ns, gc, sc, dc;
  logic [15:0] scmd;
  logic [3:0] sg, dv;
  logic [7:0] dr;
  logic dto;
  bit ok;

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0; bus.req_cmd = '0;
    repeat (3) tick();
    total_cnt++; if (bus.gnt !== 4'b0) $display("FAIL rst_gnt: got %b want 0000", bus.gnt); else pass_cnt++;
    total_cnt++; if (bus.done !== 4'b0) $display("FAIL rst_done: got %b want 0000", bus.done); else pass_cnt++;
    total_cnt++; if (bus.resp_out !== 8'h00) $display("FAIL rst_resp_out: got %h want 00", bus.resp_out); else pass_cnt++;
    total_cnt++; if (bus.timeout_err !== 1'b0) $display("FAIL rst_timeout_err: got %b want 0", bus.timeout_err); else pass_cnt++;
    total_cnt++; if (bus.cmd !== 16'h0) $display("FAIL rst_cmd: got %h want 0000", bus.cmd); else pass_cnt++;
    total_cnt++; if (bus.send_cmd !== 1'b0) $display("FAIL rst_send_cmd: got %b want 0", bus.send_cmd); else pass_cnt++;
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single();
    int c0;
    sd = 20; rd = 10; m_val = 8'hA5; m_resp_en = 1'b1;
    bus.req_cmd[31:16] = 16'h1234;
    tick();
    c0 = cyc;
    bus.req = 4'b0010;
    fork
      begin
        repeat (10) tick();
        bus.req_cmd[31:16] = 16'hFFFF;
      end
    join_none
    watch(ns, scmd, sg, gc, sc, dv, dr, dto, dc, ok);
    bus.req = '0;
    total_cnt++; if (!ok) $display("FAIL single_done_seen: no done within bound"); else pass_cnt++;
    total_cnt++; if (gc - c0 !== 1) $display("FAIL single_gnt_latency: got %0d want 1", gc - c0); else pass_cnt++;
    total_cnt++; if (sc - c0 !== 2) $display("FAIL single_send_latency: got %0d want 2", sc - c0); else pass_cnt++;
    total_cnt++; if (ns !== 1) $display("FAIL single_send_count: got %0d want 1", ns); else pass_cnt++;
    total_cnt++; if (scmd !== 16'h1234) $display("FAIL single_cmd: got %h want 1234", scmd); else pass_cnt++;
    total_cnt++; if (dv !== 4'b0010) $display("FAIL single_done: got %b want 0010", dv); else pass_cnt++;
    total_cnt++; if (dr !== 8'hA5) $display("FAIL single_resp: got %h want a5", dr); else pass_cnt++;
    total_cnt++; if (dto !== 1'b0) $display("FAIL single_timeout_err: got %b want 0", dto); else pass_cnt++;
    total_cnt++; if (dc - sc !== 31) $display("FAIL single_done_latency: got %0d want 31", dc - sc); else pass_cnt++;
    total_cnt++; if (bus.cmd !== 16'h1234) $display("FAIL single_cmd_hold: got %h want 1234", bus.cmd); else pass_cnt++;
    tick();
    total_cnt++; if (bus.done !== 4'b0 || bus.gnt !== 4'b0) $display("FAIL single_dead_cycle: got done=%b gnt=%b want 0000/0000", bus.done, bus.gnt); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int prev_dc;
    logic [3:0] exp;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    sd = 2; rd = 2; m_val = 8'h50; m_resp_en = 1'b1;
    bus.req_cmd = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
    bus.req = 4'b1111;
    prev_dc = -1;
    for (int t = 0; t < 5; t++) begin
      exp = 4'b0001 << (t % 4);
      watch(ns, scmd, sg, gc, sc, dv, dr, dto, dc, ok);
      total_cnt++; if (sg !== exp || dv !== exp) $display("FAIL rr_order[%0d]: got gnt=%b done=%b want %b", t, sg, dv, exp); else pass_cnt++;
      total_cnt++; if (scmd !== 16'hC000 + 16'(t % 4)) $display("FAIL rr_cmd[%0d]: got %h want %h", t, scmd, 16'hC000 + 16'(t % 4)); else pass_cnt++;
      total_cnt++; if (ns !== 1) $display("FAIL rr_send_count[%0d]: got %0d want 1", t, ns); else pass_cnt++;
      if (t > 0) begin
        total_cnt++; if (gc - prev_dc !== 2) $display("FAIL rr_gap[%0d]: got %0d want 2", t, gc - prev_dc); else pass_cnt++;
      end
      prev_dc = dc;
    end
    bus.req = '0;
  endtask

  task automatic test_timeout();
    sd = 5; m_resp_en = 1'b0;
    bus.req_cmd[63:48] = 16'hBEEF;
    tick();
    bus.req = 4'b1000;
    watch(ns, scmd, sg, gc, sc, dv, dr, dto, dc, ok);
    bus.req = '0;
    total_cnt++; if (dv !== 4'b1000) $display("FAIL to_done: got %b want 1000", dv); else pass_cnt++;
    total_cnt++; if (dto !== 1'b1) $display("FAIL to_err: got %b want 1", dto); else pass_cnt++;
    total_cnt++; if (dr !== 8'h00) $display("FAIL to_resp: got %h want 00", dr); else pass_cnt++;
    total_cnt++; if (dc - sc !== 100) $display("FAIL to_latency: got %0d want 100", dc - sc); else pass_cnt++;
    total_cnt++; if (scmd !== 16'hBEEF) $display("FAIL to_cmd: got %h want beef", scmd); else pass_cnt++;
    sd = 3; rd = 4; m_val = 8'h5A; m_resp_en = 1'b1;
    bus.req_cmd[15:0] = 16'h1111;
    tick();
    bus.req = 4'b0001;
    watch(ns, scmd, sg, gc, sc, dv, dr, dto, dc, ok);
    bus.req = '0;
    total_cnt++; if (dv !== 4'b0001) $display("FAIL to_next_done: got %b want 0001", dv); else pass_cnt++;
    total_cnt++; if (dr !== 8'h5A) $display("FAIL to_next_resp: got %h want 5a", dr); else pass_cnt++;
    total_cnt++; if (dto !== 1'b0) $display("FAIL to_next_err: got %b want 0", dto); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    sd = 20; rd = 79; m_val = 8'h3C; m_resp_en = 1'b1;
    bus.req_cmd[31:16] = 16'h2222;
    tick();
    bus.req = 4'b0010;
    watch(ns, scmd, sg, gc, sc, dv, dr, dto, dc, ok);
    bus.req = '0;
    total_cnt++; if (dr !== 8'h3C) $display("FAIL sim_resp: got %h want 3c", dr); else pass_cnt++;
    total_cnt++; if (dto !== 1'b0) $display("FAIL sim_err: got %b want 0", dto); else pass_cnt++;
    total_cnt++; if (dc - sc !== 100) $display("FAIL sim_latency: got %0d want 100", dc - sc); else pass_cnt++;
    // One cycle later the timeout must already have fired.
    rd = 80;
    bus.req_cmd[47:32] = 16'h3333;
    tick();
    bus.req = 4'b0100;
    watch(ns, scmd, sg, gc, sc, dv, dr, dto, dc, ok);
    bus.req = '0;
    total_cnt++; if (dto !== 1'b1) $display("FAIL late_err: got %b want 1", dto); else pass_cnt++;
    total_cnt++; if (dr !== 8'h00) $display("FAIL late_resp: got %h want 00", dr); else pass_cnt++;
    total_cnt++; if (dc - sc !== 100) $display("FAIL late_latency: got %0d want 100", dc - sc); else pass_cnt++;
    repeat (3) tick();
  endtask

  task automatic test_stray();
    int n_bad;
    n_bad = 0;
    for (int i = 0; i < 6; i++) begin
      f_resp_rdy = ~f_resp_rdy; f_resp = 8'hEE;
      tick();
      if (bus.done != 0 || bus.gnt != 0) n_bad++;
    end
    f_resp_rdy = 1'b0;
    total_cnt++; if (n_bad !== 0) $display("FAIL stray_quiet: got %0d busy cycles want 0", n_bad); else pass_cnt++;
    sd = 3; rd = 3; m_val = 8'h77;
    bus.req_cmd[47:32] = 16'h4444;
    bus.req = 4'b0100;
    watch(ns, scmd, sg, gc, sc, dv, dr, dto, dc, ok);
    bus.req = '0;
    total_cnt++; if (dv !== 4'b0100) $display("FAIL stray_done: got %b want 0100", dv); else pass_cnt++;
    total_cnt++; if (dr !== 8'h77) $display("FAIL stray_resp: got %h want 77", dr); else pass_cnt++;
    total_cnt++; if (ns !== 1) $display("FAIL stray_send_count: got %0d want 1", ns); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n_done;
    sd = 2; rd = 200; m_val = 8'h99;
    bus.req_cmd[31:16] = 16'h0F0F;
    tick();
    bus.req = 4'b0010;
    repeat (12) tick();
    total_cnt++; if (bus.gnt !== 4'b0010) $display("FAIL rmid_busy: got gnt=%b want 0010", bus.gnt); else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++; if (bus.gnt !== 4'b0) $display("FAIL rmid_gnt: got %b want 0000", bus.gnt); else pass_cnt++;
    total_cnt++; if (bus.cmd !== 16'h0) $display("FAIL rmid_cmd: got %h want 0000", bus.cmd); else pass_cnt++;
    total_cnt++; if (bus.done !== 4'b0 || bus.timeout_err !== 1'b0 || bus.resp_out !== 8'h00)
      $display("FAIL rmid_outs: got done=%b err=%b resp=%h want 0000/0/00", bus.done, bus.timeout_err, bus.resp_out);
    else pass_cnt++;
    n_done = 0;
    bus.req = 4'b1111;
    sd = 2; rd = 2; m_val = 8'h11;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done != 0) n_done++;
    end
    rst = 1'b0;
    total_cnt++; if (n_done !== 0) $display("FAIL rmid_no_done: got %0d done cycles want 0", n_done); else pass_cnt++;
    watch(ns, scmd, sg, gc, sc, dv, dr, dto, dc, ok);
    bus.req = '0;
    total_cnt++; if (sg !== 4'b0001 || dv !== 4'b0001) $display("FAIL rmid_first_grant: got gnt=%b done=%b want 0001", sg, dv); else pass_cnt++;
    total_cnt++; if (dr !== 8'h11) $display("FAIL rmid_resp: got %h want 11", dr); else pass_cnt++;
  endtask

  initial begin
    bus.req = '0;
    bus.req_cmd = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_simultaneous();
    test_stray();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/remote_cmd_arbiter.md
# remote_cmd_arbiter

Shares a single RemoteComm link between `NUM_REQ` on-chip requesters, each of which needs to issue a 16-bit command and receive an 8-bit response. Selection among pending requesters is round-robin. For the granted command, the block drives the RemoteComm `cmd`/`send_cmd` handshake, waits for `cmd_sent` and then `resp_rdy`, and returns the response to the winner. A response timeout keeps a silent remote end from hanging the link. The block sits between the test-harness command sources and the RemoteComm instance.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 2**20: cycles allowed from the first WAIT_SENT cycle until `resp_rdy` arrives.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous reset, active-high. One clock domain; all state resets asynchronously.
- `req` in NUM_REQ: request level per requester. Held high until that requester's `done` pulses.
- `req_cmd` in 16*NUM_REQ: flattened commands. Requester i uses `[16i+15:16i]`. Stable while `req[i]` is high.
- `gnt` out NUM_REQ: one-hot; the current owner, high for the whole transaction.
- `done` out NUM_REQ: one-cycle pulse to the owner when the transaction ends.
- `resp_out` out 8: response for the owner, valid while `done` is high.
- `timeout_err` out 1: high together with `done` when the transaction ended by timeout.
- `cmd` out 16: command to RemoteComm.
- `send_cmd` out 1: one-cycle launch pulse to RemoteComm.
- `cmd_sent` in 1: RemoteComm level flag. Cleared by `send_cmd`, set when both bytes are out.
- `resp_rdy` in 1: RemoteComm response-received strobe.
- `resp` in 8: RemoteComm response byte.

## Operation
- All outputs are registered. Reset values: `gnt`=0, `done`=0, `resp_out`=0, `timeout_err`=0, `cmd`=0, `send_cmd`=0, state=IDLE, `last_gnt`=NUM_REQ-1 (so requester 0 wins first), timeout counter=0.
- **IDLE**
  - If `req`≠0, pick the first set bit searching upward from `last_gnt`+1 with wrap.
  - Latch `req_cmd` of the winner into `cmd`, set `gnt`, update `last_gnt`, go to SEND.
- **SEND**
  - Assert `send_cmd` for exactly one cycle, clear the timeout counter, go to WAIT_SENT.
- **WAIT_SENT**
  - `cmd_sent`=1 → go to WAIT_RESP.
  - The counter increments every cycle.
- **WAIT_RESP**
  - `resp_rdy`=1 → capture `resp` into `resp_out`, pulse `done[owner]`, `timeout_err`=0, go to DONE.
  - The counter keeps incrementing.
- **Timeout** (WAIT_SENT or WAIT_RESP)
  - Counter reaches TIMEOUT-1 without completion → `resp_out`=8'h00, `timeout_err`=1, pulse `done`, go to DONE.
  - If `resp_rdy` and timeout occur in the same cycle, `resp_rdy` wins.
- **DONE**
  - Clear `gnt`, `done` and `timeout_err`, go to IDLE.
  - This gives one dead cycle, so the owner can drop `req` before re-arbitration.
- `cmd` holds its value from SEND until the next grant.
- Stray `resp_rdy` or `cmd_sent` edges seen in IDLE or DONE are ignored.
- If the owner drops `req` mid-transaction, the transaction still completes and `done` is still pulsed.
- Changes on `req_cmd` after the grant have no effect.
- Counter width is `$clog2(TIMEOUT)+1`. It saturates and never wraps.

## Timing
- Cycle 0: IDLE sees `req`.
- Cycle 1: `gnt` and `cmd` are valid (state SEND).
- Cycle 2: `send_cmd`=1.
- From cycle 3: WAIT_SENT polls `cmd_sent`.
- `done` asserts the cycle after `resp_rdy` is sampled high.
- Back-to-back transactions: the next grant becomes visible 2 cycles after the `done` cycle (DONE, then IDLE arbitration).
- Fairness: a continuously requesting source waits at most NUM_REQ-1 transactions.
- Asserting `rst` at any point aborts the transaction immediately. No `done` is emitted. Outputs take their reset values asynchronously.

## Structure
- Package `remote_arb_pkg`: `arb_state_t` enum {IDLE, SEND, WAIT_SENT, WAIT_RESP, DONE}, `TIMEOUT_RESP` = 8'h00, `DEFAULT_TIMEOUT`.
- Sub-module `rr_arbiter`: combinational round-robin pick.
  - Inputs: `req`, `last_gnt`.
  - Outputs: one-hot grant, grant index, `any`.
  - The FSM, counter and registers stay in `remote_cmd_arbiter`.

## Test plan
- **Single request:** `req`=4'b0010 with cmd 16'h1234; model RemoteComm sets `cmd_sent` 20 cycles later and `resp_rdy` with 8'hA5 10 cycles after that.
  - Required: `send_cmd` pulses once with `cmd`=16'h1234, then `done`=4'b0010 with `resp_out`=8'hA5 and `timeout_err`=0.
- **Round-robin:** `req`=4'b1111 held, each requester re-requesting after its `done`.
  - Required: grant order 0,1,2,3,0. `send_cmd` never pulses while a `gnt` is active from an earlier transaction.
- **Timeout:** TIMEOUT=100, `resp_rdy` never asserted.
  - Required: `done` at 100 cycles after the first WAIT_SENT cycle, `timeout_err`=1, `resp_out`=8'h00. The next request is served normally.
- **Simultaneous events:** `resp_rdy`=1 with 8'h3C in the cycle the counter hits TIMEOUT-1.
  - Required: `resp_out`=8'h3C, `timeout_err`=0.
- **Stray strobes:** `resp_rdy` pulses while in IDLE, then `req[2]` asserts.
  - Required: no `done`. The subsequent transaction returns only its own response.
- **Reset mid-operation:** `rst` asserted during WAIT_RESP.
  - Required: all outputs go to 0 in the same cycle with no `done`. After release, `req`=4'b0001 is granted first.
